// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event arbiter, plus the
// round-robin pick used by both the arbiter and its testbench model.
package btn_pkg;

  localparam int DEF_DB_CYCLES = 16;
  localparam int MAX_BTN       = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // First set bit of pend at or above ptr, wrapping at n-1 -> 0.
  function automatic logic [3:0] rr_pick(input logic [MAX_BTN-1:0] pend,
                                         input logic [3:0]         ptr,
                                         input int                 n);
    logic [3:0] sel;
    logic       found;
    int         idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_BTN; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && (k < n) && pend[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/btn_edge_ch.sv
// One button channel: 2-flop synchroniser, debounce, registered rising edge.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeat pulses.
module btn_edge_ch import btn_pkg::*; #(
  parameter int DB_CYCLES  = DEF_DB_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY  = 500000,
  parameter int RPT_PERIOD = 100000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic [1:0]       r_sync;
  logic             r_db;
  logic             r_db_q;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rpt_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], btn_in};
      r_db_q <= r_db;
      r_rise <= (r_db & ~r_db_q) | w_rpt_hit;
      if (r_sync[1] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        r_db  <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [31:0] r_rpt_cnt;
  logic        r_rpt_armed;
  logic [31:0] w_rpt_lim;

  // Counting starts the cycle after the press edge so the first repeat
  // lands exactly RPT_DELAY cycles after the press pulse.
  assign w_rpt_lim = r_rpt_armed ? 32'(RPT_PERIOD - 1) : 32'(RPT_DELAY - 1);
  assign w_rpt_hit = r_db & r_db_q & (r_rpt_cnt == w_rpt_lim);

  always_ff @(posedge clk) begin
    if (rst || !(r_db && r_db_q)) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_hit) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 32'd1;
    end
  end
`else
  assign w_rpt_hit = 1'b0;
`endif

  assign rise = r_rise;

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced button events latched as pending and offered one at a time,
// round-robin, over valid/ready. BTN_AUTOREPEAT_EN enables auto-repeat.
module btn_event_arbiter import btn_pkg::*; #(
  parameter int N_BTN      = 5,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
`ifdef BTN_AUTOREPEAT_EN
  parameter int RPT_DELAY  = 500000,
  parameter int RPT_PERIOD = 100000,
`endif
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] lost,
  input  logic [N_BTN-1:0] lost_clr
);

  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_lost_set;
  logic [3:0]       w_pick;
  logic             w_hs;

  arb_state_t       r_state;
  logic             r_evt_valid;
  logic [ID_W-1:0]  r_evt_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [N_BTN-1:0] r_pending;
  logic [N_BTN-1:0] r_lost;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_edge_ch #(
      .DB_CYCLES  (DB_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in[g]),
      .rise   (w_rise[g])
    );
  end

  assign w_hs = r_evt_valid & evt_ready;

  // NOTE: default every combinational output first so no path infers a latch.
  always_comb begin
    w_clr = '0;
    if (w_hs) w_clr[r_evt_id] = 1'b1;
  end

  // A press landing on the accept cycle re-arms pending and is not a loss.
  assign w_lost_set = w_rise & r_pending & ~w_clr;
  assign w_pick     = rr_pick(MAX_BTN'(r_pending), 4'(r_rr_ptr), N_BTN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
      r_lost      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_lost    <= (r_lost & ~lost_clr) | w_lost_set;
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_evt_id    <= w_pick[ID_W-1:0];
            r_evt_valid <= 1'b1;
            r_state     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= IDLE;
            r_rr_ptr    <= (r_evt_id == ID_W'(N_BTN - 1)) ? '0 : r_evt_id + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign pending   = r_pending;
  assign lost      = r_lost;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: a table of round-robin press vectors
// plus hand-written sequences for latency, stall, lost and repeat cases.
module tb_btn_event_arbiter;
  import btn_pkg::*;

  localparam int N    = 5;
  localparam int DB   = 16;
  localparam int ID_W = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_D   = 40;
  localparam int RPT_P   = 10;
  localparam int RPT_EXP = 4;   // press, +40, +50, +60 within a 65-cycle hold
`else
  localparam int RPT_EXP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    btn_in = '0;
  logic [N-1:0]    lost_clr = '0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N-1:0]    pending;
  logic [N-1:0]    lost;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_q[$];

  btn_event_arbiter #(
    .N_BTN      (N),
`ifdef BTN_AUTOREPEAT_EN
    .RPT_DELAY  (RPT_D),
    .RPT_PERIOD (RPT_P),
`endif
    .DB_CYCLES  (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .lost      (lost),
    .lost_clr  (lost_clr)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; a handshake is recorded just before
  // the rising edge that will complete it.
  always @(negedge clk) begin
    #4;
    if (!rst && evt_valid && evt_ready) acc_q.push_back(int'(evt_id));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    acc_q.delete();
  endtask

  typedef struct {
    int           pre;     // button pressed alone first to move the pointer, -1 for none
    logic [N-1:0] mask;    // buttons pressed together while stalled
    int           n_exp;
    int           ids[5];
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    int edges;
    int found;

    vecs[0] = '{pre: -1, mask: 5'b11001, n_exp: 3, ids: '{0, 3, 4, 0, 0}};
    vecs[1] = '{pre:  1, mask: 5'b11001, n_exp: 3, ids: '{3, 4, 0, 0, 0}};
    vecs[2] = '{pre:  4, mask: 5'b00110, n_exp: 2, ids: '{1, 2, 0, 0, 0}};
    vecs[3] = '{pre:  3, mask: 5'b11111, n_exp: 5, ids: '{4, 0, 1, 2, 3}};
    vecs[4] = '{pre:  2, mask: 5'b00100, n_exp: 1, ids: '{2, 0, 0, 0, 0}};

    // Reset state and quiet idle.
    do_reset();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_lost", 32'(lost), 0);
    bad = 0;
    repeat (100) begin
      tick(1);
      if (evt_valid || pending != '0 || lost != '0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Glitch two samples short of the debounce window.
    btn_in[2] = 1'b1;
    tick(DB - 2);
    btn_in[2] = 1'b0;
    bad = 0;
    repeat (40) begin
      tick(1);
      if (evt_valid || pending != '0) bad++;
    end
    check("glitch_ignored", bad, 0);

    // Single press latency: edges counted from the first one sampling 1.
    evt_ready = 1'b1;
    btn_in[1] = 1'b1;
    edges = 0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      edges++;
      if (evt_valid) begin
        found = 1;
        break;
      end
    end
    check("lat_found", found, 1);
    check("lat_cycles", edges, DB + 5);
    check("lat_id", 32'(evt_id), 1);
    tick(1);
    check("single_valid_drop", 32'(evt_valid), 0);
    check("single_pending_clr", 32'(pending[1]), 0);
    btn_in[1] = 1'b0;
    tick(DB + 10);
    check("single_count", acc_q.size(), 1);
    evt_ready = 1'b0;

    // Stall with three pending, then drain with the mandatory gap.
    do_reset();
    btn_in = 5'b11001;
    tick(DB + 6);
    check("stall_valid", 32'(evt_valid), 1);
    check("stall_id", 32'(evt_id), 0);
    bad = 0;
    repeat (50) begin
      tick(1);
      if (!evt_valid || evt_id != 0) bad++;
    end
    check("stall_stable", bad, 0);
    evt_ready = 1'b1;
    tick(1); check("drain_gap1", 32'(evt_valid), 0);
    tick(1); check("drain_v2", 32'(evt_valid), 1); check("drain_id2", 32'(evt_id), 3);
    tick(1); check("drain_gap2", 32'(evt_valid), 0);
    tick(1); check("drain_v3", 32'(evt_valid), 1); check("drain_id3", 32'(evt_id), 4);
    tick(1); check("drain_gap3", 32'(evt_valid), 0);
    tick(2);
    check("drain_count", acc_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("drain_order%0d", i), (i < acc_q.size()) ? acc_q[i] : -1, (i == 0) ? 0 : i + 2);
    btn_in = '0;
    tick(DB + 10);
    evt_ready = 1'b0;

    // Table: round-robin order from a known pointer.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].pre >= 0) begin
        evt_ready = 1'b1;
        btn_in[vecs[v].pre] = 1'b1;
        tick(DB + 10);
        btn_in = '0;
        tick(DB + 10);
        evt_ready = 1'b0;
        check($sformatf("v%0d_pre_count", v), acc_q.size(), 1);
        acc_q.delete();
      end
      btn_in = vecs[v].mask;
      tick(DB + 10);
      check($sformatf("v%0d_pending", v), 32'(pending), 32'(vecs[v].mask));
      evt_ready = 1'b1;
      tick(4 * N);
      evt_ready = 1'b0;
      btn_in = '0;
      check($sformatf("v%0d_count", v), acc_q.size(), vecs[v].n_exp);
      for (int i = 0; i < vecs[v].n_exp; i++)
        check($sformatf("v%0d_id%0d", v, i), (i < acc_q.size()) ? acc_q[i] : -1, vecs[v].ids[i]);
      tick(DB + 10);
    end

    // Lost: second debounced press while still pending, then write-1-to-clear.
    do_reset();
    btn_in[2] = 1'b1;
    tick(DB + 10);
    check("lost_first_pending", 32'(pending), 32'(5'b00100));
    check("lost_first_none", 32'(lost), 0);
    btn_in[2] = 1'b0;
    tick(DB + 10);
    btn_in[2] = 1'b1;
    tick(DB + 10);
    check("lost_set", 32'(lost), 32'(5'b00100));
    lost_clr[2] = 1'b1;
    tick(1);
    lost_clr = '0;
    check("lost_cleared", 32'(lost), 0);
    evt_ready = 1'b1;
    tick(6);
    check("lost_one_event", acc_q.size(), 1);
    check("lost_event_id", (acc_q.size() > 0) ? acc_q[0] : -1, 2);
    check("lost_pending_after", 32'(pending), 0);
    btn_in[2] = 1'b0;
    tick(DB + 10);
    check("lost_no_extra", acc_q.size(), 1);
    evt_ready = 1'b0;

    // Press edge coinciding with the accept of the same button.
    acc_q.delete();
    btn_in[2] = 1'b1;
    tick(DB + 10);
    btn_in[2] = 1'b0;
    tick(DB + 10);
    btn_in[2] = 1'b1;
    tick(DB + 3);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("coin_accept", acc_q.size(), 1);
    check("coin_pending_kept", 32'(pending[2]), 1);
    check("coin_no_lost", 32'(lost[2]), 0);
    evt_ready = 1'b1;
    tick(6);
    check("coin_second_event", acc_q.size(), 2);
    btn_in[2] = 1'b0;
    tick(DB + 10);
    evt_ready = 1'b0;

    // Held button: one event, or press plus repeats when auto-repeat is built in.
    do_reset();
    evt_ready = 1'b1;
    btn_in[0] = 1'b1;
    tick(65);
    btn_in[0] = 1'b0;
    tick(60);
    check("hold_count", acc_q.size(), RPT_EXP);
    bad = 0;
    foreach (acc_q[i]) if (acc_q[i] != 0) bad++;
    check("hold_ids", bad, 0);
    check("hold_no_lost", 32'(lost), 0);
    evt_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
